pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter and branch-resolution block for the MIPS8 core. It sits behind the opcode decoder and consumes the decoder's flag-write and jump-class strobes. It keeps the architectural Z/N flags, decides whether the current jump is taken, and drives the fetch PC. After a taken branch it asserts `flush` for a fixed number of cycles so that wrong-path instructions already in flight are squashed.

## Interface
Parameters:
- `PC_WIDTH`, 8, width of PC and jump target.
- `FLUSH_CYCLES`, 2, bubble cycles after a taken branch; legal range 0-7.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  freeze PC, flags and flush counter this cycle.
- `flags_write`  in  1  decoder strobe: latch ALU flags.
- `alu_zero`  in  1  ALU result == 0.
- `alu_neg`  in  1  ALU result bit 7 (signed negative).
- `is_jz`, `is_jnz`, `is_jg`, `is_jl`, `is_jump`  in  1 each  decoder jump strobes; at most one high per cycle.
- `target`  in  PC_WIDTH  absolute jump target from the instruction immediate.
- `pc`  out  PC_WIDTH  current fetch address (registered).
- `flush`  out  1  squash the instruction in decode/execute this cycle (registered).
- `taken`  out  1  one-cycle pulse: a branch was taken on the previous edge.
- `flag_z`, `flag_n`  out  1 each  architectural flags (registered).

## Operation
- States: RUN and FLUSH. The FLUSH state uses a 3-bit down-counter `fcnt`.
- Reset: `pc`=0, `flag_z`=0, `flag_n`=0, `flush`=0, `taken`=0, state=RUN, `fcnt`=0.
- Condition evaluation uses the registered flags only:
  - JZ: `flag_z`.
  - JNZ: `!flag_z`.
  - JL: `flag_n`.
  - JG: `!flag_z & !flag_n`.
  - JUMP: always taken.
- RUN, `stall`=1: every register holds; `taken` drops to 0.
- RUN, no stall, condition true:
  - `pc` <= `target`, `taken` <= 1.
  - If FLUSH_CYCLES>0: state <= FLUSH, `fcnt` <= FLUSH_CYCLES, `flush` <= 1.
- RUN, no stall, otherwise: `pc` <= `pc`+1.
- RUN, no stall, `flags_write`=1: `flag_z` <= `alu_zero`, `flag_n` <= `alu_neg`.
- FLUSH, no stall:
  - `pc` <= `pc`+1 (fetching down the target path).
  - `fcnt` decrements.
  - When `fcnt` reaches 1, the next state is RUN and `flush` <= 0.
  - Jump strobes and `flags_write` are ignored, because those instructions are squashed.
- FLUSH, `stall`=1: `pc`, `fcnt`, `flush` and flags all hold.
- PC arithmetic is modulo 2^PC_WIDTH: `pc` at 0xFF with PC_WIDTH=8 increments to 0x00 with no error.
- Multiple jump strobes high at once is illegal input. The priority is JUMP > JZ > JNZ > JG > JL, and this priority is documented and verified.

## Timing
- Branch latency: a jump strobe sampled at edge N gives `pc`=`target` and `taken`=1 after edge N, and `flush`=1 for FLUSH_CYCLES non-stalled cycles after edge N.
- Flag latency: flags written at edge N are visible to a jump evaluated at edge N+1. The same-cycle CMP+Jcc case cannot occur, because they are different opcodes.
- `taken` is high for exactly one cycle per taken branch, with no extra cycles during stalls.
- Reset asserted mid-FLUSH aborts the flush. The next cycle shows `flush`=0 and `pc`=0.
- FLUSH_CYCLES=0: a taken branch never leaves RUN and `flush` stays 0.

## Test plan
- Reset then 5 free-running cycles -> `pc` sequence 0,1,2,3,4,5; `flush`=0; flags 0.
- `flags_write`=1 with `alu_zero`=1, next cycle `is_jz`=1 and `target`=0x40 -> `pc`=0x40, `taken` pulse, `flush` high for exactly 2 cycles while `pc` runs 0x41, 0x42, then RUN resumes.
- `flag_z`=0 and `flag_n`=1, apply `is_jg` -> not taken, `pc`+1; apply `is_jl` -> taken.
- `stall` asserted during the second FLUSH cycle for 3 cycles -> `pc`, `flush` and `fcnt` frozen; flush completes after the stall with 2 flush cycles total counted.
- `pc`=0xFF with no branch -> `pc`=0x00. Separately, `is_jump` together with `flags_write` while in FLUSH -> both ignored.
- `rst` asserted one cycle into FLUSH -> `pc`=0, `flush`=0, `taken`=0 on the next cycle.

Source files
------------

// File: rtl/pc_branch_unit.sv
// ============================================================================
//  Module   : pc_branch_unit
//  Purpose  : Fetch PC, architectural Z/N flags, branch resolution and
//             post-branch flush sequencing for the MIPS8 core.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_branch_unit #(
    parameter int PC_WIDTH     = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flags_write,
    input  logic                alu_zero,
    input  logic                alu_neg,
    input  logic                is_jz,
    input  logic                is_jnz,
    input  logic                is_jg,
    input  logic                is_jl,
    input  logic                is_jump,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic                taken,
    output logic                flag_z,
    output logic                flag_n
);

    localparam logic [2:0]          C_FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [PC_WIDTH-1:0] C_PC_ONE     = PC_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [2:0]          r_fcnt, w_fcnt_nxt;
    logic                r_flush, w_flush_nxt;
    logic                r_taken, w_taken_nxt;
    logic                r_flag_z, w_flag_z_nxt;
    logic                r_flag_n, w_flag_n_nxt;
    logic                w_cond;

    // Only the highest-priority strobe is evaluated if several are (illegally) high.
    always_comb begin
        w_cond = 1'b0;
        if (is_jump)     w_cond = 1'b1;
        else if (is_jz)  w_cond = r_flag_z;
        else if (is_jnz) w_cond = ~r_flag_z;
        else if (is_jg)  w_cond = ~r_flag_z & ~r_flag_n;
        else if (is_jl)  w_cond = r_flag_n;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_fcnt_nxt   = r_fcnt;
        w_flush_nxt  = r_flush;
        w_taken_nxt  = 1'b0;
        w_flag_z_nxt = r_flag_z;
        w_flag_n_nxt = r_flag_n;
        if (!stall) begin
            case (r_state)
                ST_RUN: begin
                    if (flags_write) begin
                        w_flag_z_nxt = alu_zero;
                        w_flag_n_nxt = alu_neg;
                    end
                    if (w_cond) begin
                        w_pc_nxt    = target;
                        w_taken_nxt = 1'b1;
                        if (FLUSH_CYCLES > 0) begin
                            w_state_nxt = ST_FLUSH;
                            w_fcnt_nxt  = C_FLUSH_INIT;
                            w_flush_nxt = 1'b1;
                        end
                    end else begin
                        w_pc_nxt = r_pc + C_PC_ONE;
                    end
                end
                ST_FLUSH: begin
                    // Strobes and flag writes here belong to squashed instructions.
                    w_pc_nxt   = r_pc + C_PC_ONE;
                    w_fcnt_nxt = r_fcnt - 3'd1;
                    if (r_fcnt == 3'd1) begin
                        w_state_nxt = ST_RUN;
                        w_flush_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_flush_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= '0;
            r_fcnt   <= 3'd0;
            r_flush  <= 1'b0;
            r_taken  <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_flush  <= w_flush_nxt;
            r_taken  <= w_taken_nxt;
            r_flag_z <= w_flag_z_nxt;
            r_flag_n <= w_flag_n_nxt;
        end
    end

    assign pc     = r_pc;
    assign flush  = r_flush;
    assign taken  = r_taken;
    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
// ============================================================================
//  Module   : tb_pc_branch_unit
//  Purpose  : Directed self-checking bench for pc_branch_unit (defaults).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_branch_unit;

    logic       clk = 1'b0;
    logic       rst, stall, flags_write, alu_zero, alu_neg;
    logic       is_jz, is_jnz, is_jg, is_jl, is_jump;
    logic [7:0] target;
    logic [7:0] pc;
    logic       flush, taken, flag_z, flag_n;

    int n_tests = 0;
    int n_fail  = 0;

    pc_branch_unit #(.PC_WIDTH(8), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flags_write(flags_write),
        .alu_zero(alu_zero), .alu_neg(alu_neg),
        .is_jz(is_jz), .is_jnz(is_jnz), .is_jg(is_jg), .is_jl(is_jl),
        .is_jump(is_jump), .target(target),
        .pc(pc), .flush(flush), .taken(taken), .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_pc, input logic e_flush,
                           input logic e_taken);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
        chk({tag, ".taken"}, 32'(taken), 32'(e_taken));
    endtask

    task automatic clr_strobes();
        is_jz = 0; is_jnz = 0; is_jg = 0; is_jl = 0; is_jump = 0; flags_write = 0;
    endtask

    initial begin
        rst = 1; stall = 0; alu_zero = 0; alu_neg = 0; target = 8'h00;
        clr_strobes();
        step(); step();
        chk_out("reset", 8'h00, 0, 0);
        chk("reset.flag_z", 32'(flag_z), 0);
        chk("reset.flag_n", 32'(flag_n), 0);
        rst = 0;

        for (int i = 1; i <= 5; i++) begin
            step();
            chk_out($sformatf("free%0d", i), 8'(i), 0, 0);
        end

        // CMP result zero, then JZ to 0x40
        flags_write = 1; alu_zero = 1; alu_neg = 0;
        step();
        chk_out("cmpz", 8'h06, 0, 0);
        chk("cmpz.flag_z", 32'(flag_z), 1);
        clr_strobes(); is_jz = 1; target = 8'h40;
        step();
        chk_out("jz_taken", 8'h40, 1, 1);
        clr_strobes();
        step();
        chk_out("jz_flush2", 8'h41, 1, 0);
        step();
        chk_out("jz_done", 8'h42, 0, 0);
        step();
        chk_out("jz_run", 8'h43, 0, 0);

        // Z=0 N=1: JG not taken, JL taken
        flags_write = 1; alu_zero = 0; alu_neg = 1;
        step();
        chk("cmpn.flag_z", 32'(flag_z), 0);
        chk("cmpn.flag_n", 32'(flag_n), 1);
        clr_strobes(); is_jg = 1; target = 8'h80;
        step();
        chk_out("jg_not", 8'h45, 0, 0);
        clr_strobes(); is_jl = 1;
        step();
        chk_out("jl_taken", 8'h80, 1, 1);
        clr_strobes();
        step();
        chk_out("jl_flush2", 8'h81, 1, 0);

        // Stall during the second flush cycle
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall%0d", i), 8'h81, 1, 0);
            chk($sformatf("stall%0d.fcnt", i), 32'(dut.r_fcnt), 1);
        end
        stall = 0;
        step();
        chk_out("stall_done", 8'h82, 0, 0);

        // Priority: JZ beats JL (Z=0 -> not taken though JL would be)
        is_jz = 1; is_jl = 1; target = 8'h10;
        step();
        chk_out("prio_jz_jl", 8'h83, 0, 0);
        // JUMP beats JZ -> taken
        clr_strobes(); is_jump = 1; is_jz = 1; target = 8'hFD;
        step();
        chk_out("prio_jump", 8'hFD, 1, 1);

        // Strobes and flag write inside FLUSH are ignored
        clr_strobes(); is_jump = 1; target = 8'h20; flags_write = 1; alu_zero = 1; alu_neg = 0;
        step();
        chk_out("flush_ign", 8'hFE, 1, 0);
        chk("flush_ign.flag_z", 32'(flag_z), 0);
        chk("flush_ign.flag_n", 32'(flag_n), 1);
        clr_strobes();
        step();
        chk_out("pre_wrap", 8'hFF, 0, 0);
        step();
        chk_out("wrap", 8'h00, 0, 0);

        // Stall in RUN blocks a jump and drops taken
        stall = 1; is_jump = 1; target = 8'h33;
        step();
        chk_out("run_stall", 8'h00, 0, 0);
        stall = 0;
        step();
        chk_out("jump_after_stall", 8'h33, 1, 1);

        // Reset one cycle into FLUSH
        clr_strobes(); rst = 1;
        step();
        chk_out("rst_flush", 8'h00, 0, 0);
        chk("rst_flush.flag_n", 32'(flag_n), 0);
        rst = 0;
        step();
        chk_out("post_rst", 8'h01, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
